// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared definitions for the instruction-fetch stage.
//   state_t    : fetch FSM encoding (BOOT=0, RUN=1)
//   IQ_DEPTH   : depth of the fetch queue that buffers returned words
//   iq_entry_t : one queue entry {pc, inst} at the default 16/16 widths
//   can_issue  : occupancy rule that decides whether a new fetch may start
package ifetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int IQ_DEPTH = 2;
  localparam int DEF_AW   = 16;
  localparam int DEF_DW   = 16;

  typedef struct packed {
    logic [DEF_AW-1:0] pc;
    logic [DEF_DW-1:0] inst;
  } iq_entry_t;

  // A fetch may start when every word already owed to the queue (stored
  // entries plus the one returning this cycle), less the one leaving this
  // cycle, still leaves a free slot. Written as a + b < 2 + pop so the
  // arithmetic never goes negative.
  function automatic logic can_issue(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    return ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if -- bundle of the fetch stage's memory-side and decode-side signals.
//   imem_addr   : word address presented to the synchronous instruction memory
//   imem_dout   : memory data for the address sampled at the previous edge
//   inst/inst_pc: instruction at the queue head and its PC
//   inst_valid  : head is valid
//   inst_ready  : decode takes the head this cycle
//   redirect    : kill queued and in-flight words, restart at redirect_pc
//   redirect_pc : restart address
// modport master: the fetch stage; modport slave: memory + decode side.
//
// Handshake: the head transfers on every edge where inst_valid and
// inst_ready are both 1. While inst_valid=1 and inst_ready=0, inst and
// inst_pc hold. inst_valid never depends on inst_ready. A redirect in the
// same cycle voids the transfer: the consumer drops its current instruction.
interface ifetch_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_dout;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  modport master (
    output imem_addr,
    input  imem_dout,
    output inst,
    output inst_pc,
    output inst_valid,
    input  inst_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    output imem_dout,
    input  inst,
    input  inst_pc,
    input  inst_valid,
    output inst_ready,
    output redirect,
    output redirect_pc
  );

endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue -- 2-entry synchronous FIFO of {pc, inst} fetch results.
//   clk, rst_n        : clock, asynchronous active-low reset (clears contents)
//   flush_i           : drop all entries; overrides push and pop
//   push_i            : write {push_pc_i, push_inst_i}
//   pop_i             : remove the head
//   count_o           : number of stored entries, 0..2
//   head_valid_o      : count_o != 0
//   head_pc_o/inst_o  : head entry, driven straight from storage
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_pc_i,
  input  logic [DW-1:0] push_inst_i,
  input  logic          pop_i,
  output logic [1:0]    count_o,
  output logic          head_valid_o,
  output logic [AW-1:0] head_pc_o,
  output logic [DW-1:0] head_inst_o
);

  localparam logic [1:0] FULL = 2'(IQ_DEPTH);

  // Two slots, so the read/write pointers are single bits.
  logic [AW-1:0] pc_mem_q   [IQ_DEPTH];
  logic [DW-1:0] inst_mem_q [IQ_DEPTH];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_i & ~flush_i & (count_q != 2'd0);
    // A push into a full queue is accepted only if a pop frees a slot now.
    do_push  = push_i & ~flush_i & ((count_q != FULL) | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (do_push) begin
      pc_mem_q[wr_ptr_q]   <= push_pc_i;
      inst_mem_q[wr_ptr_q] <= push_inst_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_pc_o    = pc_mem_q[rd_ptr_q];
  assign head_inst_o  = inst_mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// ifetch -- instruction-fetch stage in front of a synchronous-read memory.
// Issues word addresses, captures each word one cycle later into a 2-entry
// queue and hands the queue head to decode over valid/ready. A redirect
// flushes everything and restarts fetch at redirect_pc in the same cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : ifetch_if.master (memory address/data, decode handshake,
//                 redirect)
//   state_o     : FSM state (BOOT/RUN), debug
//   count_o     : queue occupancy, debug
//   inflight_o  : a memory word is returning this cycle, debug
module ifetch
  import ifetch_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  ifetch_if.master   bus,
  output state_t     state_o,
  output logic [1:0] count_o,
  output logic       inflight_o
);

  state_t        state_q;
  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  // Address of the fetch now in flight; tags the word when it returns.
  logic [AW-1:0] last_addr_q, last_addr_d;

  logic [AW-1:0] fetch_addr;
  logic          head_pop;
  logic          issue;
  logic          iq_push, iq_pop;
  logic [1:0]    iq_count;

  always_comb begin
    fetch_addr  = bus.redirect ? bus.redirect_pc : pc_q;
    head_pop    = bus.inst_valid & bus.inst_ready;
    // Redirect and BOOT always issue; otherwise issue only if the word can
    // be stored when it comes back, so the queue cannot overflow.
    issue       = bus.redirect | (state_q == BOOT) |
                  can_issue(iq_count, inflight_q, head_pop);
    pc_d        = pc_q;
    inflight_d  = 1'b0;
    last_addr_d = last_addr_q;
    if (issue) begin
      pc_d        = fetch_addr + AW'(1);
      inflight_d  = 1'b1;
      last_addr_d = fetch_addr;
    end
  end

  // Redirect kills the returning word and voids any pop in the same cycle.
  assign iq_push = inflight_q & ~bus.redirect;
  assign iq_pop  = head_pop & ~bus.redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      last_addr_q <= '0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN:  state_q <= RUN;
      endcase
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      last_addr_q <= last_addr_d;
    end
  end

  ifetch_queue #(
    .AW (AW),
    .DW (DW)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (bus.redirect),
    .push_i       (iq_push),
    .push_pc_i    (last_addr_q),
    .push_inst_i  (bus.imem_dout),
    .pop_i        (iq_pop),
    .count_o      (iq_count),
    .head_valid_o (bus.inst_valid),
    .head_pc_o    (bus.inst_pc),
    .head_inst_o  (bus.inst)
  );

  assign bus.imem_addr = fetch_addr;
  assign state_o       = state_q;
  assign count_o       = iq_count;
  assign inflight_o    = inflight_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch -- directed bench for ifetch. Memory model returns 0x1000+addr
// one edge after the address is presented. Each task starts just after a
// rising edge (inputs driven there) and samples outputs at the falling edge.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  state_t     state_o;
  logic [1:0] count_o;
  logic       inflight_o;

  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp;

  ifetch_if #(.AW(AW), .DW(DW)) bus ();

  ifetch #(
    .DW       (DW),
    .AW       (AW),
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .state_o    (state_o),
    .count_o    (count_o),
    .inflight_o (inflight_o)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) bus.imem_dout <= mem_word(bus.imem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n           = 1'b0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    checks++;
    if (bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0000", bus.imem_addr);
    end
    checks++;
    if ({bus.inst_valid, bus.inst_pc, bus.inst} !== 33'd0) begin
      errors++;
      $display("FAIL reset_head: got v=%b pc=%h inst=%h expected all zero",
               bus.inst_valid, bus.inst_pc, bus.inst);
    end
    checks++;
    if ({state_o, count_o, inflight_o} !== {BOOT, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got st=%0d cnt=%0d infl=%b expected 0/0/0",
               state_o, count_o, inflight_o);
    end
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Entered in cycle 1 (first cycle after reset release).
  task automatic test_boot();
    bus.inst_ready = 1'b1;
    bus.redirect   = 1'b0;
    sample();
    checks++;
    if ({state_o, bus.imem_addr, bus.inst_valid} !== {BOOT, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL boot_c1: got st=%0d addr=%h v=%b expected 0/0000/0",
               state_o, bus.imem_addr, bus.inst_valid);
    end
    next_cycle();
    sample();
    checks++;
    if ({state_o, bus.imem_addr, bus.inst_valid} !== {RUN, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL boot_c2: got st=%0d addr=%h v=%b expected 1/0001/0",
               state_o, bus.imem_addr, bus.inst_valid);
    end
    next_cycle();
    // Cycles 3..6: head k = cycle-3, address issued = cycle-1.
    for (int k = 0; k < 4; k++) begin
      sample();
      checks++;
      if ({bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr} !==
          {1'b1, 16'(k), mem_word(16'(k)), 16'(k + 2)}) begin
        errors++;
        $display("FAIL boot_stream: got v=%b pc=%h inst=%h addr=%h expected pc=%h inst=%h addr=%h",
                 bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr,
                 16'(k), mem_word(16'(k)), 16'(k + 2));
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if ({bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr} !==
          {1'b1, 16'h0004, 16'h1004, 16'h0006}) begin
        errors++;
        $display("FAIL bp_hold: got v=%b pc=%h inst=%h addr=%h expected 0004/1004/0006",
                 bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr);
      end
      if (i >= 1) begin
        checks++;
        if ({count_o, inflight_o} !== {2'd2, 1'b0}) begin
          errors++;
          $display("FAIL bp_full: got cnt=%0d infl=%b expected 2/0", count_o, inflight_o);
        end
      end
      next_cycle();
    end
    bus.inst_ready = 1'b1;
    for (int k = 4; k < 9; k++) exp_q.push_back({16'(k), mem_word(16'(k))});
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      sample();
      checks++;
      if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL bp_resume: got v=%b pc=%h inst=%h expected pc=%h inst=%h",
                 bus.inst_valid, bus.inst_pc, bus.inst, exp[31:16], exp[15:0]);
      end
      next_cycle();
    end
  endtask

  // Redirect while stalled with a word in flight (head 0x0009 held).
  task automatic test_redirect();
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    sample();
    checks++;
    if ({bus.imem_addr, bus.inst_valid, inflight_o} !== {16'h0040, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL redir_issue: got addr=%h v=%b infl=%b expected 0040/1/1",
               bus.imem_addr, bus.inst_valid, inflight_o);
    end
    next_cycle();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    sample();
    checks++;
    if ({bus.inst_valid, count_o} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL redir_bubble: got v=%b cnt=%0d expected 0/0", bus.inst_valid, count_o);
    end
    next_cycle();
    for (int k = 16'h40; k < 16'h44; k++) exp_q.push_back({16'(k), mem_word(16'(k))});
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      sample();
      checks++;
      if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL redir_stream: got v=%b pc=%h inst=%h expected pc=%h inst=%h",
                 bus.inst_valid, bus.inst_pc, bus.inst, exp[31:16], exp[15:0]);
      end
      next_cycle();
    end
  endtask

  // Redirect in the same cycle decode accepts the head (head 0x0044).
  task automatic test_redirect_pop();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0080;
    sample();
    checks++;
    if ({bus.inst_valid, bus.inst_pc, bus.imem_addr} !== {1'b1, 16'h0044, 16'h0080}) begin
      errors++;
      $display("FAIL rp_issue: got v=%b pc=%h addr=%h expected 1/0044/0080",
               bus.inst_valid, bus.inst_pc, bus.imem_addr);
    end
    next_cycle();
    bus.redirect = 1'b0;
    sample();
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_bubble: got v=%b expected 0", bus.inst_valid);
    end
    next_cycle();
    for (int k = 16'h80; k < 16'h83; k++) exp_q.push_back({16'(k), mem_word(16'(k))});
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      sample();
      checks++;
      if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL rp_stream: got v=%b pc=%h inst=%h expected pc=%h inst=%h",
                 bus.inst_valid, bus.inst_pc, bus.inst, exp[31:16], exp[15:0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    sample();
    checks++;
    if (bus.imem_addr !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_issue: got addr=%h expected fffe", bus.imem_addr);
    end
    next_cycle();
    bus.redirect = 1'b0;
    next_cycle();
    exp_q.push_back({16'hFFFE, 16'h0FFE});
    exp_q.push_back({16'hFFFF, 16'h0FFF});
    exp_q.push_back({16'h0000, 16'h1000});
    exp_q.push_back({16'h0001, 16'h1001});
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      sample();
      checks++;
      if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL wrap_stream: got v=%b pc=%h inst=%h expected pc=%h inst=%h",
                 bus.inst_valid, bus.inst_pc, bus.inst, exp[31:16], exp[15:0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr} !== 49'd0) begin
      errors++;
      $display("FAIL mid_reset_out: got v=%b pc=%h inst=%h addr=%h expected all zero",
               bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr);
    end
    checks++;
    if ({state_o, count_o, inflight_o} !== {BOOT, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state: got st=%0d cnt=%0d infl=%b expected 0/0/0",
               state_o, count_o, inflight_o);
    end
    next_cycle();
    rst_n = 1'b1;
    test_boot();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
